// File: rtl/scan_capture_if.sv
// Bus bundle for scan_capture: multiplexed display inputs and decoded frame outputs.
// The slave modport is the capture block; the master modport is whatever drives the display bus.
interface scan_capture_if #(
  parameter int unsigned ERR_W = 8
);
  logic [6:0]       seg;
  logic [3:0]       an;
  logic             clr_err;
  logic [6:0]       digit1;
  logic [6:0]       digit2;
  logic [6:0]       digit3;
  logic [6:0]       digit4;
  logic [3:0]       sym1;
  logic [3:0]       sym2;
  logic [3:0]       sym3;
  logic [3:0]       sym4;
  logic             frame_valid;
  logic             scan_err;
  logic [ERR_W-1:0] err_cnt;

  modport master (
    output seg, an, clr_err,
    input  digit1, digit2, digit3, digit4, sym1, sym2, sym3, sym4,
    input  frame_valid, scan_err, err_cnt
  );

  modport slave (
    input  seg, an, clr_err,
    output digit1, digit2, digit3, digit4, sym1, sym2, sym3, sym4,
    output frame_valid, scan_err, err_cnt
  );
endinterface

// File: rtl/scan_capture.sv
// Captures a 4-digit multiplexed 7-segment scan into whole frames and decodes each digit.
// Out-of-order or multi-hot anode codes abort the frame and are counted as scan errors.
module scan_capture #(
  parameter int unsigned ERR_W = 8
) (
  input logic           fast_clk,
  input logic           rst_n,
  scan_capture_if.slave bus
);

  typedef enum logic [2:0] {StHunt, StGot1, StGot2, StGot3, StGot4} state_e;

  localparam logic [3:0]       AnD1    = 4'b0111;
  localparam logic [3:0]       AnD2    = 4'b1011;
  localparam logic [3:0]       AnD3    = 4'b1101;
  localparam logic [3:0]       AnD4    = 4'b1110;
  localparam logic [3:0]       AnBlank = 4'b1111;
  localparam logic [6:0]       SegOff  = 7'b1111111;
  localparam logic [ERR_W-1:0] ErrMax  = '1;

  function automatic logic [3:0] decode(input logic [6:0] s);
    case (s)
      7'b1000000: decode = 4'd0;
      7'b1111001: decode = 4'd1;
      7'b0100100: decode = 4'd2;
      7'b0110000: decode = 4'd3;
      7'b0011001: decode = 4'd4;
      7'b0010010: decode = 4'd5;
      7'b0000010: decode = 4'd6;
      7'b1111000: decode = 4'd7;
      7'b0000000: decode = 4'd8;
      7'b0010000: decode = 4'd9;
      default:    decode = 4'hF;
    endcase
  endfunction

  state_e           state_q;
  logic [6:0]       work1_q, work2_q, work3_q;
  logic [6:0]       digit1_q, digit2_q, digit3_q, digit4_q;
  logic [3:0]       sym1_q, sym2_q, sym3_q, sym4_q;
  logic             frame_valid_q;
  logic             scan_err_q;
  logic [ERR_W-1:0] err_cnt_q;

  logic [3:0] own_code;
  logic [3:0] next_code;
  logic       advance;
  logic       illegal;

  // Dwell on the current digit or a blank strobe is benign; anything else mid-frame is an error.
  always_comb begin
    own_code  = AnBlank;
    next_code = AnD1;
    unique case (state_q)
      StGot1:  begin own_code = AnD1; next_code = AnD2; end
      StGot2:  begin own_code = AnD2; next_code = AnD3; end
      StGot3:  begin own_code = AnD3; next_code = AnD4; end
      StGot4:  begin own_code = AnD4; next_code = AnD1; end
      default: ;
    endcase
    advance = (bus.an == next_code);
    illegal = (state_q != StHunt) && !advance && (bus.an != own_code) && (bus.an != AnBlank);
  end

  always_ff @(posedge fast_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StHunt;
      work1_q       <= SegOff;
      work2_q       <= SegOff;
      work3_q       <= SegOff;
      digit1_q      <= SegOff;
      digit2_q      <= SegOff;
      digit3_q      <= SegOff;
      digit4_q      <= SegOff;
      sym1_q        <= 4'hF;
      sym2_q        <= 4'hF;
      sym3_q        <= 4'hF;
      sym4_q        <= 4'hF;
      frame_valid_q <= 1'b0;
      scan_err_q    <= 1'b0;
      err_cnt_q     <= '0;
    end else begin
      frame_valid_q <= 1'b0;
      if (advance) begin
        unique case (state_q)
          StGot1: begin work2_q <= bus.seg; state_q <= StGot2; end
          StGot2: begin work3_q <= bus.seg; state_q <= StGot3; end
          StGot3: begin
            digit1_q      <= work1_q;
            digit2_q      <= work2_q;
            digit3_q      <= work3_q;
            digit4_q      <= bus.seg;
            sym1_q        <= decode(work1_q);
            sym2_q        <= decode(work2_q);
            sym3_q        <= decode(work3_q);
            sym4_q        <= decode(bus.seg);
            frame_valid_q <= 1'b1;
            state_q       <= StGot4;
          end
          default: begin work1_q <= bus.seg; state_q <= StGot1; end
        endcase
      end else if (illegal) begin
        // A stray digit-1 strobe is still a valid frame start, so resynchronise on it.
        if (bus.an == AnD1) begin
          work1_q <= bus.seg;
          state_q <= StGot1;
        end else begin
          state_q <= StHunt;
        end
      end

      if (illegal) begin
        scan_err_q <= 1'b1;
        if (bus.clr_err)             err_cnt_q <= ERR_W'(1);
        else if (err_cnt_q != ErrMax) err_cnt_q <= err_cnt_q + 1'b1;
      end else if (bus.clr_err) begin
        scan_err_q <= 1'b0;
        err_cnt_q  <= '0;
      end
    end
  end

  assign bus.digit1      = digit1_q;
  assign bus.digit2      = digit2_q;
  assign bus.digit3      = digit3_q;
  assign bus.digit4      = digit4_q;
  assign bus.sym1        = sym1_q;
  assign bus.sym2        = sym2_q;
  assign bus.sym3        = sym3_q;
  assign bus.sym4        = sym4_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.scan_err    = scan_err_q;
  assign bus.err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_scan_capture.sv
// Scoreboard bench for scan_capture: a digit-position model predicts each cycle's outputs,
// and a monitor compares them one cycle after every driven strobe.
module tb_scan_capture;

  localparam int unsigned ERR_W = 2;
  localparam logic [3:0]  D1 = 4'b0111;
  localparam logic [3:0]  D2 = 4'b1011;
  localparam logic [3:0]  D3 = 4'b1101;
  localparam logic [3:0]  D4 = 4'b1110;
  localparam logic [3:0]  BL = 4'b1111;

  typedef struct packed {
    logic             fv;
    logic             err;
    logic [ERR_W-1:0] cnt;
    logic [27:0]      digs;
    logic [15:0]      syms;
  } exp_t;

  logic fast_clk = 1'b0;
  logic rst_n;

  scan_capture_if #(.ERR_W(ERR_W)) bus ();

  scan_capture #(.ERR_W(ERR_W)) u_dut (
    .fast_clk (fast_clk),
    .rst_n    (rst_n),
    .bus      (bus)
  );

  always #5 fast_clk = ~fast_clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  // Reference model state: how many digits of the current frame are in hand (0 = hunting).
  int          m_pos;
  logic [6:0]  m_work[1:4];
  logic [27:0] m_digs;
  logic [15:0] m_syms;
  logic        m_err;
  int          m_cnt;
  logic [6:0]  glyph[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] model_decode(input logic [6:0] s);
    for (int i = 0; i < 10; i++) if (glyph[i] == s) return 4'(i);
    return 4'hF;
  endfunction

  // 1..4 for a legal digit strobe, 0 for blank, -1 for any multi-hot code.
  function automatic int an_index(input logic [3:0] a);
    for (int k = 1; k <= 4; k++) if (a == (4'b1111 ^ (4'b1000 >> (k - 1)))) return k;
    return (a == BL) ? 0 : -1;
  endfunction

  function automatic logic [3:0] code_of(input int k);
    return 4'b1111 ^ (4'b1000 >> (k - 1));
  endfunction

  task automatic model_reset();
    m_pos  = 0;
    for (int k = 1; k <= 4; k++) m_work[k] = 7'h7F;
    m_digs = {4{7'h7F}};
    m_syms = 16'hFFFF;
    m_err  = 1'b0;
    m_cnt  = 0;
  endtask

  task automatic model_step(input logic [3:0] a, input logic [6:0] s, input logic c,
                            output logic fv);
    int  idx;
    logic bad;
    idx = an_index(a);
    fv  = 1'b0;
    bad = 1'b0;
    if (m_pos == 0) begin
      if (idx == 1) begin m_work[1] = s; m_pos = 1; end
    end else if (idx == 0 || idx == m_pos) begin
      // dwell or blank: nothing sampled
    end else if (idx == (m_pos % 4) + 1) begin
      m_work[idx] = s;
      m_pos = idx;
      if (idx == 4) begin
        m_digs = {m_work[1], m_work[2], m_work[3], m_work[4]};
        m_syms = {model_decode(m_work[1]), model_decode(m_work[2]),
                  model_decode(m_work[3]), model_decode(m_work[4])};
        fv = 1'b1;
      end
    end else begin
      bad = 1'b1;
      if (idx == 1) begin m_work[1] = s; m_pos = 1; end
      else m_pos = 0;
    end
    if (bad) begin
      m_err = 1'b1;
      m_cnt = c ? 1 : ((m_cnt + 1 > (1 << ERR_W) - 1) ? (1 << ERR_W) - 1 : m_cnt + 1);
    end else if (c) begin
      m_err = 1'b0;
      m_cnt = 0;
    end
  endtask

  task automatic cycle(input logic [3:0] a, input logic [6:0] s, input logic c);
    logic fv;
    exp_t e;
    @(negedge fast_clk);
    bus.an      = a;
    bus.seg     = s;
    bus.clr_err = c;
    model_step(a, s, c, fv);
    e.fv   = fv;
    e.err  = m_err;
    e.cnt  = ERR_W'(m_cnt);
    e.digs = m_digs;
    e.syms = m_syms;
    exp_q.push_back(e);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_digits"}, 64'({bus.digit1, bus.digit2, bus.digit3, bus.digit4}),
          64'({4{7'h7F}}));
    check({tag, "_syms"}, 64'({bus.sym1, bus.sym2, bus.sym3, bus.sym4}), 64'(16'hFFFF));
    check({tag, "_flags"}, 64'({bus.frame_valid, bus.scan_err}), 64'(0));
    check({tag, "_err_cnt"}, 64'(bus.err_cnt), 64'(0));
  endtask

  // Monitor: every driven strobe has one expectation, due just after the following edge.
  always @(posedge fast_clk) begin
    #1;
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      check("frame_valid", 64'(bus.frame_valid), 64'(mon_e.fv));
      check("scan_err", 64'(bus.scan_err), 64'(mon_e.err));
      check("err_cnt", 64'(bus.err_cnt), 64'(mon_e.cnt));
      check("digits", 64'({bus.digit1, bus.digit2, bus.digit3, bus.digit4}), 64'(mon_e.digs));
      check("syms", 64'({bus.sym1, bus.sym2, bus.sym3, bus.sym4}), 64'(mon_e.syms));
    end
  end

  logic [3:0] r_an, prev_an;
  logic [6:0] r_seg;
  int         gen_k;
  int         r;

  initial begin
    glyph = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
              7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    rst_n       = 1'b0;
    bus.an      = BL;
    bus.seg     = 7'h7F;
    bus.clr_err = 1'b0;
    model_reset();
    repeat (3) @(posedge fast_clk);
    #1;
    check_reset_values("reset");
    @(negedge fast_clk);
    rst_n = 1'b1;

    // Basic frame 1,2,3,4
    cycle(D1, 7'b1111001, 1'b0);
    cycle(D2, 7'b0100100, 1'b0);
    cycle(D3, 7'b0110000, 1'b0);
    cycle(D4, 7'b0011001, 1'b0);
    cycle(BL, 7'h7F, 1'b0);

    // Each strobe dwells three cycles; only the first cycle's segments count
    for (int f = 0; f < 2; f++) begin
      for (int k = 1; k <= 4; k++) begin
        cycle(code_of(k), glyph[(k + 4 * f) % 10], 1'b0);
        cycle(code_of(k), 7'($urandom), 1'b0);
        cycle(code_of(k), 7'($urandom), 1'b0);
      end
    end

    // Out-of-order strobe aborts the frame
    cycle(D1, glyph[9], 1'b0);
    cycle(D3, glyph[8], 1'b0);
    cycle(BL, 7'h7F, 1'b0);

    // Multi-hot in GOT2 with a simultaneous clear: the error wins
    cycle(D1, glyph[5], 1'b0);
    cycle(D2, glyph[6], 1'b0);
    cycle(4'b0000, glyph[7], 1'b1);
    cycle(BL, 7'h7F, 1'b0);

    // Saturation: five illegal events into a 2-bit counter, then clear
    cycle(BL, 7'h7F, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cycle(D1, glyph[i], 1'b0);
      cycle(4'b0011, glyph[i + 1], 1'b0);
    end
    cycle(BL, 7'h7F, 1'b1);
    cycle(BL, 7'h7F, 1'b0);

    // Random scan traffic, mostly in order with dwells, blanks and stray codes
    gen_k   = 1;
    prev_an = BL;
    for (int i = 0; i < 1500; i++) begin
      r = int'($urandom_range(99));
      if (r < 65) begin
        r_an  = code_of(gen_k);
        gen_k = (gen_k % 4) + 1;
      end else if (r < 80) r_an = prev_an;
      else if (r < 90)     r_an = BL;
      else                 r_an = 4'($urandom);
      r_seg = ($urandom_range(1) == 0) ? glyph[$urandom_range(9)] : 7'($urandom);
      cycle(r_an, r_seg, ($urandom_range(49) == 0));
      prev_an = r_an;
    end
    cycle(BL, 7'h7F, 1'b0);

    // Asynchronous reset while in GOT3, then a fresh frame is required
    cycle(D1, glyph[2], 1'b0);
    cycle(D2, glyph[3], 1'b0);
    cycle(D3, glyph[4], 1'b0);
    @(posedge fast_clk);
    #3;
    rst_n  = 1'b0;
    bus.an = BL;
    #1;
    check_reset_values("async_reset");
    model_reset();
    @(posedge fast_clk);
    @(negedge fast_clk);
    rst_n = 1'b1;
    cycle(D2, glyph[1], 1'b0);
    cycle(D3, glyph[1], 1'b0);
    cycle(D4, glyph[1], 1'b0);
    cycle(D1, glyph[7], 1'b0);
    cycle(D2, 7'b1010101, 1'b0);
    cycle(D3, glyph[0], 1'b0);
    cycle(D4, glyph[8], 1'b0);
    cycle(BL, 7'h7F, 1'b0);

    repeat (3) @(posedge fast_clk);
    #2;
    check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/scan_capture.md
SCAN_CAPTURE -- requirements
Module: scan_capture

Interface
REQ-001 The block SHALL have parameter ERR_W, default 8, giving the width of the saturating error counter.
REQ-002 fast_clk  in  1  the single clock; seg and an are synchronous to it.
REQ-003 rst_n  in  1  reset, asynchronous assert and active-low.
REQ-004 seg  in  7  multiplexed segment bus, active-low, bit order gfedcba.
REQ-005 an  in  4  digit anode strobes, active-low; legal one-hot-low codes are 0111 (digit1), 1011 (digit2), 1101 (digit3), 1110 (digit4); 1111 is blank.
REQ-006 clr_err  in  1  synchronous clear of scan_err and err_cnt.
REQ-007 digit1, digit2, digit3, digit4  out  7 each  raw segment pattern of the last complete frame.
REQ-008 sym1, sym2, sym3, sym4  out  4 each  decoded value of digitN: 0-9, or 4'hF when not a decimal glyph.
REQ-009 frame_valid  out  1  one-cycle pulse when digit1..4 and sym1..4 update.
REQ-010 scan_err  out  1  sticky illegal-scan flag.
REQ-011 err_cnt  out  ERR_W  saturating count of illegal-scan events.

Function
REQ-012 The block SHALL run the FSM states HUNT, GOT1, GOT2, GOT3 and GOT4, where GOTk means digit k was captured last.
REQ-013 HUNT: an=0111 SHALL capture seg into work1 and go to GOT1; every other code SHALL keep HUNT with no error.
REQ-014 GOTk, for k=1..3: an equal to the digit k+1 code SHALL capture seg into work(k+1) and advance.
REQ-015 GOT4: an=0111 SHALL capture work1 and go to GOT1, which starts the next frame.
REQ-016 In any GOTk, an equal to digit k's own code (dwell), or an=1111, SHALL hold state without recapture: only the first cycle of each dwell is sampled.
REQ-017 An illegal event SHALL be raised for any other code seen in GOTk:
  - a multi-hot-low code, such as 0000 or 0011;
  - an out-of-order legal code.
REQ-018 On an illegal event the FSM SHALL go to HUNT, unless the code is 0111, in which case it SHALL capture work1 and go to GOT1.
REQ-019 An illegal event SHALL set scan_err and increment err_cnt.
REQ-020 err_cnt SHALL saturate at 2^ERR_W-1.
REQ-021 Frame commit SHALL occur on the edge that captures digit4, in the GOT3->GOT4 transition.
REQ-022 On that edge, digit1..3 SHALL load from work1..3 and digit4 SHALL load from seg.
REQ-023 On that edge, sym1..4 SHALL load the decode of the same values, and frame_valid SHALL be 1 for exactly the following cycle.
REQ-024 digitN and symN SHALL hold between commits; a partial frame aborted by an illegal event SHALL never reach the outputs.
REQ-025 The decode SHALL map 1000000->0, 1111001->1, 0100100->2, 0110000->3, 0011001->4, 0010010->5, 0000010->6, 1111000->7, 0000000->8, 0010000->9, and any other pattern -> 4'hF.
REQ-026 When clr_err=1 with no illegal event in the same cycle, the next cycle SHALL give scan_err=0 and err_cnt=0.
REQ-027 When clr_err=1 and an illegal event occur in the same cycle, the error SHALL win: scan_err=1 and err_cnt=1.
REQ-028 Output latency SHALL be one cycle from sampling to a registered output; all outputs SHALL be registered.

Reset
REQ-029 While rst_n=0, regardless of fast_clk, the block SHALL force:
  - the FSM to HUNT;
  - work1..4 and digit1..4 to 7'b1111111;
  - sym1..4 to 4'hF;
  - frame_valid, scan_err and err_cnt to 0.
REQ-030 Deasserting rst_n mid-frame SHALL restart in HUNT: a frame SHALL commit only after a fresh 0111 is seen.

Verification
REQ-031 Reset release, then an=0111/1011/1101/1110 with seg=1111001/0100100/0110000/0011001, one cycle each -> one cycle after the 1110 edge: frame_valid=1, sym1..4=1,2,3,4, scan_err=0.
REQ-032 Each code held 3 cycles, with seg changed during dwell cycles 2-3 -> the captured digits equal the first-cycle values, and exactly one frame_valid pulse per frame.
REQ-033 Sequence 0111, 1101 -> scan_err=1, err_cnt=1, FSM in HUNT; the previous digit outputs are unchanged and there is no frame_valid pulse.
REQ-034 an=0000 while in GOT2, with clr_err=1 in the same cycle -> scan_err=1, err_cnt=1.
REQ-035 With ERR_W=2, 5 illegal events -> err_cnt=3; then clr_err -> err_cnt=0, scan_err=0.
REQ-036 rst_n pulsed low in GOT3 -> every output is at its reset value asynchronously, and the next commit requires a full 0111..1110 sequence; seg=1010101 decodes to sym=4'hF.
